// File: rtl/wb_width_bridge.sv
// rtl/wb_width_bridge.sv - Wishbone classic wide-master to narrow-slave width down-converter
// One windowed master access becomes one slave beat per lane, lane 0 at bits [0:SW-1] (big-endian).
module wb_width_bridge #(
  parameter int unsigned   MW         = 32,
  parameter int unsigned   SW         = 8,
  parameter int unsigned   AW         = 32,
  parameter logic [AW-1:0] WIN_BASE   = 32'h8000_0000,
  parameter logic [AW-1:0] WIN_MASK   = 32'hff00_0000,
  parameter bit            SKIP_UNSEL = 1'b1,
  parameter int unsigned   TIMEOUT    = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [0:AW-1]   m_adr_i,
  input  logic [0:MW-1]   m_dat_i,
  output logic [0:MW-1]   m_dat_o,
  input  logic [0:MW/8-1] m_sel_i,
  input  logic            m_we_i,
  input  logic            m_stb_i,
  input  logic            m_cyc_i,
  output logic            m_ack_o,
  output logic            m_err_o,
  output logic [0:AW-1]   s_adr_o,
  output logic [0:SW-1]   s_dat_o,
  input  logic [0:SW-1]   s_dat_i,
  output logic [0:SW/8-1] s_sel_o,
  output logic            s_we_o,
  output logic            s_stb_o,
  output logic            s_cyc_o,
  input  logic            s_ack_i,
  input  logic            s_err_i
);

  localparam int unsigned R   = MW / SW;
  localparam int unsigned MBY = MW / 8;
  localparam int unsigned SBY = SW / 8;
  localparam int unsigned MB  = $clog2(MBY);
  localparam int unsigned SB  = $clog2(SBY);
  localparam int unsigned BW  = (R > 1) ? $clog2(R) : 1;
  localparam int unsigned TW  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [AW-1:0] ADR_KEEP = ~(AW'((64'd1 << MB) - 64'd1));

  typedef enum logic [1:0] {
    S_IDLE,
    S_BEAT,
    S_DONE,
    S_ERR
  } state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [BW-1:0]   r_beat;
  logic [TW-1:0]   r_tmo;
  logic [0:MW-1]   r_rdat;
  logic [0:MW-1]   r_mdat;

  logic            w_hit;
  logic            w_req;
  logic            w_abort;
  logic            w_tmo;
  logic [0:R-1]    w_lane_sel;
  logic [BW-1:0]   w_first;
  logic            w_any;
  logic [BW-1:0]   w_next_beat;
  logic            w_has_next;

  assign w_hit   = (m_adr_i & WIN_MASK) == WIN_BASE;
  assign w_req   = m_cyc_i & m_stb_i & w_hit;
  assign w_abort = ~m_cyc_i | ~m_stb_i;
  assign w_tmo   = (TIMEOUT != 0) && (r_tmo == TW'(TIMEOUT));

  always_comb begin
    w_lane_sel = '0;
    for (int i = 0; i < int'(R); i++) begin
      w_lane_sel[i] = (SKIP_UNSEL == 1'b0) || (|m_sel_i[i*SBY +: SBY]);
    end
  end

  // Descending scan so the lowest qualifying lane wins both searches.
  always_comb begin
    w_first     = '0;
    w_any       = 1'b0;
    w_next_beat = '0;
    w_has_next  = 1'b0;
    for (int i = int'(R) - 1; i >= 0; i--) begin
      if (w_lane_sel[i]) begin
        w_first = BW'(i);
        w_any   = 1'b1;
      end
      if (w_lane_sel[i] && (i > int'(r_beat))) begin
        w_next_beat = BW'(i);
        w_has_next  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_next_state = w_any ? S_BEAT : S_DONE;
        end
      end
      S_BEAT: begin
        if (w_abort) begin
          w_next_state = S_IDLE;
        end else if (s_err_i) begin
          w_next_state = S_ERR;
        end else if (s_ack_i) begin
          w_next_state = w_has_next ? S_BEAT : S_DONE;
        end else if (w_tmo) begin
          w_next_state = S_ERR;
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      S_ERR:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    s_stb_o = (r_state == S_BEAT);
    m_ack_o = (r_state == S_DONE);
    m_err_o = (r_state == S_ERR);
    m_dat_o = (r_state == S_DONE) ? r_rdat : r_mdat;
  end

  assign s_cyc_o = m_cyc_i & w_hit;
  assign s_we_o  = m_we_i;
  assign s_adr_o = (m_adr_i & ADR_KEEP) | (AW'(r_beat) << SB);
  assign s_dat_o = m_dat_i[32'(r_beat)*SW +: SW];
  assign s_sel_o = m_sel_i[32'(r_beat)*SBY +: SBY];

  // r_mdat keeps the last completed read so m_dat_o is stable outside DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_beat <= '0;
      r_tmo  <= '0;
      r_rdat <= '0;
      r_mdat <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            r_rdat <= '0;
            r_beat <= w_first;
            r_tmo  <= '0;
          end
        end
        S_BEAT: begin
          if (w_abort || s_err_i) begin
            r_tmo <= '0;
          end else if (s_ack_i) begin
            r_rdat[32'(r_beat)*SW +: SW] <= s_dat_i;
            r_tmo <= '0;
            if (w_has_next) begin
              r_beat <= w_next_beat;
            end
          end else if (TIMEOUT != 0) begin
            r_tmo <= r_tmo + TW'(1);
          end
        end
        S_DONE: r_mdat <= r_rdat;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_width_bridge.sv
// tb/tb_wb_width_bridge.sv - directed self-checking bench for wb_width_bridge
module tb_wb_width_bridge;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int n_run  = 0;
  int n_fail = 0;

  logic [0:31] a_m_adr, a_m_dat_i, a_m_dat_o, a_s_adr;
  logic [0:3]  a_m_sel;
  logic        a_m_we, a_m_stb, a_m_cyc, a_m_ack, a_m_err;
  logic [0:7]  a_s_dat_o, a_s_dat_i;
  logic [0:0]  a_s_sel;
  logic        a_s_we, a_s_stb, a_s_cyc, a_s_ack, a_s_err;

  logic [0:31] b_m_adr, b_s_adr;
  logic [0:63] b_m_dat_i, b_m_dat_o;
  logic [0:7]  b_m_sel;
  logic        b_m_we, b_m_stb, b_m_cyc, b_m_ack, b_m_err;
  logic [0:15] b_s_dat_o, b_s_dat_i;
  logic [0:1]  b_s_sel;
  logic        b_s_we, b_s_stb, b_s_cyc, b_s_ack, b_s_err;

  wb_width_bridge #(
    .MW(32), .SW(8), .AW(32), .WIN_BASE(32'h8000_0000), .WIN_MASK(32'hff00_0000),
    .SKIP_UNSEL(1'b1), .TIMEOUT(8)
  ) dut_a (
    .clk(clk), .reset(reset),
    .m_adr_i(a_m_adr), .m_dat_i(a_m_dat_i), .m_dat_o(a_m_dat_o), .m_sel_i(a_m_sel),
    .m_we_i(a_m_we), .m_stb_i(a_m_stb), .m_cyc_i(a_m_cyc), .m_ack_o(a_m_ack), .m_err_o(a_m_err),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat_o), .s_dat_i(a_s_dat_i), .s_sel_o(a_s_sel),
    .s_we_o(a_s_we), .s_stb_o(a_s_stb), .s_cyc_o(a_s_cyc), .s_ack_i(a_s_ack), .s_err_i(a_s_err)
  );

  wb_width_bridge #(
    .MW(64), .SW(16), .AW(32), .WIN_BASE(32'h8000_0000), .WIN_MASK(32'hff00_0000),
    .SKIP_UNSEL(1'b1), .TIMEOUT(0)
  ) dut_b (
    .clk(clk), .reset(reset),
    .m_adr_i(b_m_adr), .m_dat_i(b_m_dat_i), .m_dat_o(b_m_dat_o), .m_sel_i(b_m_sel),
    .m_we_i(b_m_we), .m_stb_i(b_m_stb), .m_cyc_i(b_m_cyc), .m_ack_o(b_m_ack), .m_err_o(b_m_err),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat_o), .s_dat_i(b_s_dat_i), .s_sel_o(b_s_sel),
    .s_we_o(b_s_we), .s_stb_o(b_s_stb), .s_cyc_o(b_s_cyc), .s_ack_i(b_s_ack), .s_err_i(b_s_err)
  );

  int          beats, acks, errs, ack_cyc, err_cyc, stb_cyc;
  bit          scyc_any, we_seen;
  logic [31:0] badr [8];
  logic [15:0] bdat [8];
  logic [1:0]  bsel [8];
  logic [15:0] rd   [8];
  logic [63:0] rdat;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_results();
    beats = 0; acks = 0; errs = 0; ack_cyc = -1; err_cyc = -1; stb_cyc = 0;
    scyc_any = 1'b0; we_seen = 1'b0;
  endtask

  // Slave model: acks (or errs) the cycle after it first sees a beat's strobe.
  task automatic run_a(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input logic we, input int err_beat, input bit silent,
                       input int abort_beat, input int rst_beat, input int ncyc);
    bit prev_stb, prev_resp, fin;
    prev_stb = 1'b0; prev_resp = 1'b0; fin = 1'b0;
    clear_results();
    @(posedge clk); #1;
    a_m_adr = adr; a_m_dat_i = dat; a_m_sel = sel; a_m_we = we;
    a_m_cyc = 1'b1; a_m_stb = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(posedge clk); #1;
      reset = 1'b0;
      a_s_ack = 1'b0; a_s_err = 1'b0;
      if (a_m_ack) begin acks++; ack_cyc = t; rdat = 64'(a_m_dat_o); end
      if (a_m_err) begin errs++; err_cyc = t; end
      if (a_s_cyc) scyc_any = 1'b1;
      if (fin) begin a_m_cyc = 1'b0; a_m_stb = 1'b0; end
      if (a_m_ack || a_m_err) fin = 1'b1;
      if (a_s_stb) begin
        stb_cyc++;
        if (prev_stb && !prev_resp) begin
          if (!silent) begin
            if (beats == err_beat) begin
              a_s_err = 1'b1;
            end else begin
              a_s_ack   = 1'b1;
              a_s_dat_i = rd[beats][7:0];
              badr[beats] = a_s_adr;
              bdat[beats] = 16'(a_s_dat_o);
              bsel[beats] = 2'(a_s_sel);
              if (a_s_we) we_seen = 1'b1;
              beats++;
            end
          end
        end else begin
          if (beats == abort_beat) begin
            a_m_cyc = 1'b0;
            #1;
            check("abort_s_cyc_drop", 64'(a_s_cyc), 64'd0);
          end
          if (beats == rst_beat) begin
            reset = 1'b1;
            fin   = 1'b1;
          end
        end
      end
      prev_stb  = a_s_stb;
      prev_resp = a_s_ack | a_s_err;
    end
    a_m_cyc = 1'b0; a_m_stb = 1'b0;
  endtask

  task automatic run_b(input logic [31:0] adr, input logic [7:0] sel, input int ncyc);
    bit prev_stb, prev_resp, fin;
    prev_stb = 1'b0; prev_resp = 1'b0; fin = 1'b0;
    clear_results();
    @(posedge clk); #1;
    b_m_adr = adr; b_m_dat_i = '0; b_m_sel = sel; b_m_we = 1'b0;
    b_m_cyc = 1'b1; b_m_stb = 1'b1;
    for (int t = 1; t <= ncyc; t++) begin
      @(posedge clk); #1;
      b_s_ack = 1'b0;
      if (b_m_ack) begin acks++; ack_cyc = t; rdat = b_m_dat_o; end
      if (b_m_err) begin errs++; err_cyc = t; end
      if (b_s_cyc) scyc_any = 1'b1;
      if (fin) begin b_m_cyc = 1'b0; b_m_stb = 1'b0; end
      if (b_m_ack || b_m_err) fin = 1'b1;
      if (b_s_stb) begin
        stb_cyc++;
        if (prev_stb && !prev_resp) begin
          b_s_ack   = 1'b1;
          b_s_dat_i = rd[beats];
          badr[beats] = b_s_adr;
          bdat[beats] = b_s_dat_o;
          bsel[beats] = b_s_sel;
          if (b_s_we) we_seen = 1'b1;
          beats++;
        end
      end
      prev_stb  = b_s_stb;
      prev_resp = b_s_ack;
    end
    b_m_cyc = 1'b0; b_m_stb = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    a_m_adr = '0; a_m_dat_i = '0; a_m_sel = '0; a_m_we = 1'b0; a_m_stb = 1'b0; a_m_cyc = 1'b0;
    a_s_dat_i = '0; a_s_ack = 1'b0; a_s_err = 1'b0;
    b_m_adr = '0; b_m_dat_i = '0; b_m_sel = '0; b_m_we = 1'b0; b_m_stb = 1'b0; b_m_cyc = 1'b0;
    b_s_dat_i = '0; b_s_ack = 1'b0; b_s_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ack", 64'(a_m_ack), 64'd0);
    check("rst_m_err", 64'(a_m_err), 64'd0);
    check("rst_s_stb", 64'(a_s_stb), 64'd0);
    check("rst_m_dat", 64'(a_m_dat_o), 64'd0);
    check("rst_b_s_stb", 64'(b_s_stb), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    rd[0] = 16'h11; rd[1] = 16'h22; rd[2] = 16'h33; rd[3] = 16'h44;
    run_a(32'h8000_1004, 32'h0, 4'b1111, 1'b0, -1, 1'b0, -1, -1, 16);
    check("t1_beats", 64'(beats), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_adr%0d", i), 64'(badr[i]), 64'(32'h8000_1004 + i));
    end
    check("t1_m_dat", rdat, 64'h1122_3344);
    check("t1_acks", 64'(acks), 64'd1);
    check("t1_errs", 64'(errs), 64'd0);

    run_a(32'h8000_1004, 32'h0, 4'b1111, 1'b0, 1, 1'b0, -1, -1, 16);
    check("t4_err_errs", 64'(errs), 64'd1);
    check("t4_err_acks", 64'(acks), 64'd0);
    check("t4_err_beats", 64'(beats), 64'd1);
    check("t4_err_dat_hold", 64'(a_m_dat_o), 64'h1122_3344);

    run_a(32'h8000_0020, 32'h0, 4'b0000, 1'b0, -1, 1'b0, -1, -1, 8);
    check("t3_nosel_stb", 64'(stb_cyc), 64'd0);
    check("t3_nosel_ack_cyc", 64'(ack_cyc), 64'd1);
    check("t3_nosel_acks", 64'(acks), 64'd1);
    check("t3_nosel_dat", rdat, 64'd0);

    run_a(32'h8000_1004, 32'h0, 4'b1111, 1'b0, -1, 1'b1, -1, -1, 20);
    check("t4_tmo_errs", 64'(errs), 64'd1);
    check("t4_tmo_err_cyc", 64'(err_cyc), 64'd10);
    check("t4_tmo_acks", 64'(acks), 64'd0);

    run_a(32'h8000_0010, 32'hA1B2_C3D4, 4'b0101, 1'b1, -1, 1'b0, -1, -1, 16);
    check("t2_beats", 64'(beats), 64'd2);
    check("t2_adr0", 64'(badr[0]), 64'h8000_0011);
    check("t2_dat0", 64'(bdat[0]), 64'hB2);
    check("t2_adr1", 64'(badr[1]), 64'h8000_0013);
    check("t2_dat1", 64'(bdat[1]), 64'hD4);
    check("t2_sel0", 64'(bsel[0]), 64'd1);
    check("t2_we", 64'(we_seen), 64'd1);
    check("t2_acks", 64'(acks), 64'd1);

    run_a(32'h0000_0000, 32'h0, 4'b1111, 1'b0, -1, 1'b0, -1, -1, 8);
    check("t3_miss_s_cyc", 64'(scyc_any), 64'd0);
    check("t3_miss_stb", 64'(stb_cyc), 64'd0);
    check("t3_miss_acks", 64'(acks), 64'd0);
    check("t3_miss_errs", 64'(errs), 64'd0);

    run_a(32'h8000_1004, 32'h0, 4'b1111, 1'b0, -1, 1'b0, 0, -1, 8);
    check("t5_abort_acks", 64'(acks), 64'd0);
    check("t5_abort_errs", 64'(errs), 64'd0);
    check("t5_abort_stb", 64'(stb_cyc), 64'd1);

    run_a(32'h8000_1004, 32'h0, 4'b1111, 1'b0, -1, 1'b0, -1, 2, 12);
    check("t5_rst_acks", 64'(acks), 64'd0);
    check("t5_rst_errs", 64'(errs), 64'd0);
    check("t5_rst_stb", 64'(stb_cyc), 64'd5);
    check("t5_rst_beats", 64'(beats), 64'd2);

    rd[0] = 16'hAA; rd[1] = 16'hBB;
    run_a(32'h8000_2004, 32'h0, 4'b0011, 1'b0, -1, 1'b0, -1, -1, 16);
    check("t5_next_beats", 64'(beats), 64'd2);
    check("t5_next_adr0", 64'(badr[0]), 64'h8000_2006);
    check("t5_next_adr1", 64'(badr[1]), 64'h8000_2007);
    check("t5_next_dat", rdat, 64'h0000_AABB);
    check("t5_next_acks", 64'(acks), 64'd1);

    rd[0] = 16'h1111; rd[1] = 16'h2222; rd[2] = 16'h3333; rd[3] = 16'h4444;
    run_b(32'h8000_0008, 8'hff, 16);
    check("t6_beats", 64'(beats), 64'd4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t6_adr%0d", i), 64'(badr[i]), 64'(32'h8000_0008 + 2 * i));
      check($sformatf("t6_sel%0d", i), 64'(bsel[i]), 64'd3);
    end
    check("t6_m_dat", rdat, 64'h1111_2222_3333_4444);
    check("t6_acks", 64'(acks), 64'd1);
    check("t6_errs", 64'(errs), 64'd0);
    check("t6_we", 64'(we_seen), 64'd0);
    check("t6_s_cyc", 64'(scyc_any), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
